// File: rtl/load_refill_ctrl_pkg.sv
// rtl/load_refill_ctrl_pkg.sv - shared load-width codes, refill FSM states and AXI size codes
package load_refill_ctrl_pkg;

    localparam logic [1:0] LSWIDTH_BYTE = 2'd0;
    localparam logic [1:0] LSWIDTH_HALF = 2'd1;
    localparam logic [1:0] LSWIDTH_WORD = 2'd2;

    localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        LRC_IDLE  = 2'd0,
        LRC_AR    = 2'd1,
        LRC_RDATA = 2'd2
    } lrc_state_e;

endpackage

// File: rtl/load_refill_ctrl_if.sv
// rtl/load_refill_ctrl_if.sv - AXI-style read address/data channel between refill controller and memory
interface load_refill_ctrl_if;

    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rready;

    modport master (
        output arvalid, araddr, arlen, arsize, rready,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, rready,
        output arready, rvalid, rdata, rlast
    );

endinterface

// File: rtl/load_refill_ctrl_linebuf.sv
// rtl/load_refill_ctrl_linebuf.sv - single refill line storage; per-word valids under LOAD_REFILL_EARLY_HIT_EN
module load_refill_linebuf #(
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
`ifdef LOAD_REFILL_EARLY_HIT_EN
    ,
    input  logic                  clr,
    output logic [LINE_WORDS-1:0] wvalid
`endif
);

    logic [31:0] mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

`ifdef LOAD_REFILL_EARLY_HIT_EN
    // Valids restart with each new burst so stale words of the previous line never hit.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            wvalid <= '0;
        end else if (we) begin
            wvalid[widx] <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/load_refill_ctrl.sv
// rtl/load_refill_ctrl.sv - load-miss refill: one read burst into a single-line buffer (option: LOAD_REFILL_EARLY_HIT_EN)
module load_refill_ctrl
    import load_refill_ctrl_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int LINE_OFS_W = $clog2(LINE_WORDS) + 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_rdctrl_en,
    input  logic [7:0]  i_rdctrl_fid,
    input  logic [31:0] i_rdctrl_addr,
    input  logic        i_rdctrl_uncached,
    input  logic [1:0]  i_rdctrl_lswidth,
    input  logic [31:0] i_qaddr,
    output logic        o_qhit,
    output logic [31:0] o_qdata,
    input  logic        i_consume,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_fill_done,
    output logic [7:0]  o_fill_fid,
    load_refill_ctrl_if.master mem
);

    localparam int IDX_W = LINE_OFS_W - 2;

    lrc_state_e       state;
    logic             entry_valid;
    logic             discard;
    logic             uncached_q;
    logic [7:0]       fid_q;
    logic [29:0]      tag_q;
    logic [IDX_W-1:0] beat_cnt;
    logic [IDX_W-1:0] rd_idx;
    logic             req_dup;
    logic             accept;
    logic             drop;
    logic             unused_qaddr_lsb;

    // Cached entries compare line address only; uncached compare the full word address.
    function automatic logic tag_match(input logic [31:0] a);
        if (uncached_q) begin
            return a[31:2] == tag_q;
        end
        return a[31:LINE_OFS_W] == tag_q[29:IDX_W];
    endfunction

    assign req_dup          = entry_valid && tag_match(i_rdctrl_addr);
    assign accept           = (state == LRC_IDLE) && !i_flush && i_rdctrl_en && !req_dup;
    assign drop             = discard || i_flush;
    assign rd_idx           = uncached_q ? '0 : i_qaddr[LINE_OFS_W-1:2];
    assign o_busy           = (state != LRC_IDLE);
    assign unused_qaddr_lsb = &{1'b0, i_qaddr[1:0]};

`ifdef LOAD_REFILL_EARLY_HIT_EN
    logic [LINE_WORDS-1:0] word_valid;
`endif

    load_refill_linebuf #(.LINE_WORDS(LINE_WORDS)) u_linebuf (
        .clk    (clk),
        .resetn (resetn),
        .we     ((state == LRC_RDATA) && mem.rvalid),
        .widx   (beat_cnt),
        .wdata  (mem.rdata),
        .ridx   (rd_idx),
        .rdata  (o_qdata)
`ifdef LOAD_REFILL_EARLY_HIT_EN
        ,
        .clr    (accept),
        .wvalid (word_valid)
`endif
    );

    always_comb begin
        o_qhit = 1'b0;
        if (state == LRC_IDLE) begin
            o_qhit = entry_valid && tag_match(i_qaddr);
        end
`ifdef LOAD_REFILL_EARLY_HIT_EN
        else if (state == LRC_RDATA) begin
            o_qhit = !discard && tag_match(i_qaddr) && word_valid[rd_idx];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= LRC_IDLE;
            entry_valid <= 1'b0;
            discard     <= 1'b0;
            uncached_q  <= 1'b0;
            fid_q       <= '0;
            tag_q       <= '0;
            beat_cnt    <= '0;
            mem.arvalid <= 1'b0;
            mem.araddr  <= '0;
            mem.arlen   <= '0;
            mem.arsize  <= '0;
            mem.rready  <= 1'b0;
            o_fill_done <= 1'b0;
            o_fill_fid  <= '0;
        end else begin
            o_fill_done <= 1'b0;
            case (state)
                LRC_IDLE: begin
                    if (i_flush) begin
                        entry_valid <= 1'b0;
                    end else if (accept) begin
                        state       <= LRC_AR;
                        entry_valid <= 1'b0;
                        discard     <= 1'b0;
                        fid_q       <= i_rdctrl_fid;
                        uncached_q  <= i_rdctrl_uncached;
                        mem.arvalid <= 1'b1;
                        if (i_rdctrl_uncached) begin
                            tag_q      <= i_rdctrl_addr[31:2];
                            mem.arlen  <= 4'd0;
                            if (i_rdctrl_lswidth == LSWIDTH_BYTE) begin
                                mem.araddr <= i_rdctrl_addr;
                                mem.arsize <= AXI_SIZE_BYTE;
                            end else begin
                                mem.araddr <= {i_rdctrl_addr[31:2], 2'b00};
                                mem.arsize <= AXI_SIZE_WORD;
                            end
                        end else begin
                            tag_q      <= {i_rdctrl_addr[31:LINE_OFS_W], {IDX_W{1'b0}}};
                            mem.araddr <= {i_rdctrl_addr[31:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
                            mem.arlen  <= 4'(LINE_WORDS - 1);
                            mem.arsize <= AXI_SIZE_WORD;
                        end
                    end else if (i_consume && uncached_q) begin
                        // A device register read must never be served twice.
                        entry_valid <= 1'b0;
                    end
                end
                LRC_AR: begin
                    if (i_flush) begin
                        discard <= 1'b1;
                    end
                    if (mem.arready) begin
                        state       <= LRC_RDATA;
                        mem.arvalid <= 1'b0;
                        mem.rready  <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                LRC_RDATA: begin
                    if (i_flush) begin
                        discard <= 1'b1;
                    end
                    if (mem.rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (mem.rlast) begin
                            state       <= LRC_IDLE;
                            mem.rready  <= 1'b0;
                            entry_valid <= !drop;
                            o_fill_done <= !drop;
                            if (!drop) begin
                                o_fill_fid <= fid_q;
                            end
                        end
                    end
                end
                default: state <= LRC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_refill_ctrl.sv
// tb/tb_load_refill_ctrl.sv - directed and randomized refill bursts checked against a line-buffer model
module tb_load_refill_ctrl;
    import load_refill_ctrl_pkg::*;

    localparam int LW         = 4;
    localparam int LINE_BYTES = LW * 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_fid = '0;
    logic [31:0] rd_addr = '0;
    logic        rd_unc = 1'b0;
    logic [1:0]  rd_lsw = '0;
    logic [31:0] qaddr = '0;
    logic        qhit;
    logic [31:0] qdata;
    logic        consume = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        fill_done;
    logic [7:0]  fill_fid;

    load_refill_ctrl_if mem_if();

    load_refill_ctrl #(.LINE_WORDS(LW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .i_rdctrl_en       (rd_en),
        .i_rdctrl_fid      (rd_fid),
        .i_rdctrl_addr     (rd_addr),
        .i_rdctrl_uncached (rd_unc),
        .i_rdctrl_lswidth  (rd_lsw),
        .i_qaddr           (qaddr),
        .o_qhit            (qhit),
        .o_qdata           (qdata),
        .i_consume         (consume),
        .i_flush           (flush),
        .o_busy            (busy),
        .o_fill_done       (fill_done),
        .o_fill_fid        (fill_fid),
        .mem               (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ar_count = 0;

    always @(posedge clk) begin
        if (resetn && mem_if.arvalid && mem_if.arready) ar_count <= ar_count + 1;
    end

    // Reference model: what the buffer should hold, in address arithmetic terms.
    logic        m_valid = 1'b0;
    logic        m_unc = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_line [LW];

    function automatic logic m_hit(input logic [31:0] q);
        if (!m_valid) return 1'b0;
        if (m_unc) return (q / 4) == (m_addr / 4);
        return (q / LINE_BYTES) == (m_addr / LINE_BYTES);
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] q);
        return m_unc ? m_line[0] : m_line[(q % LINE_BYTES) / 4];
    endfunction

    function automatic logic [31:0] exp_araddr(input logic [31:0] a, input logic unc, input logic [1:0] lsw);
        if (!unc) return a - (a % LINE_BYTES);
        if (lsw == LSWIDTH_BYTE) return a;
        return a - (a % 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arvalid"}, mem_if.arvalid, 0);
        check({tag, "_araddr"}, mem_if.araddr, 0);
        check({tag, "_arlen"}, mem_if.arlen, 0);
        check({tag, "_arsize"}, mem_if.arsize, 0);
        check({tag, "_rready"}, mem_if.rready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fill_done"}, fill_done, 0);
        check({tag, "_fill_fid"}, fill_fid, 0);
        check({tag, "_qhit"}, qhit, 0);
        check({tag, "_qdata"}, qdata, 0);
    endtask

    // One complete request: AR with optional arready delay, all beats, optional flush at a beat.
    task automatic burst(input logic [31:0] addr, input logic unc, input logic [1:0] lsw,
                         input int ar_delay, input int flush_at, input logic [31:0] data_base);
        int          n = unc ? 1 : LW;
        int          base_cnt = ar_count;
        logic [7:0]  fid = 8'($urandom);
        logic [31:0] ea = exp_araddr(addr, unc, lsw);
        logic [31:0] beats [LW];
        logic        flushed = 1'b0;
        for (int i = 0; i < LW; i++) beats[i] = (data_base != 0) ? data_base + i : $urandom;
        rd_en = 1'b1; rd_addr = addr; rd_unc = unc; rd_lsw = lsw; rd_fid = fid;
        tick();
        m_valid = 1'b0;
        check("ar_valid", mem_if.arvalid, 1);
        check("ar_addr", mem_if.araddr, ea);
        check("ar_len", mem_if.arlen, unc ? 0 : LW - 1);
        check("ar_size", mem_if.arsize, (unc && lsw == LSWIDTH_BYTE) ? 0 : 2);
        check("busy_ar", busy, 1);
        qaddr = addr; #1;
        check("qhit_in_ar", qhit, 0);
        for (int d = 0; d < ar_delay; d++) begin
            tick();
            check("ar_hold", mem_if.arvalid, 1);
            check("ar_stable", mem_if.araddr, ea);
        end
        mem_if.arready = 1'b1;
        tick();
        mem_if.arready = 1'b0;
        check("ar_once", ar_count - base_cnt, 1);
        check("rready_on", mem_if.rready, 1);
        for (int i = 0; i < n; i++) begin
            mem_if.rvalid = 1'b1; mem_if.rdata = beats[i]; mem_if.rlast = (i == n - 1);
            if (i == flush_at) begin flush = 1'b1; flushed = 1'b1; end
            if (i == n - 1) rd_en = 1'b0;
            tick();
            mem_if.rvalid = 1'b0; mem_if.rlast = 1'b0; flush = 1'b0;
            if (i < n - 1) begin
                check("rready_drain", mem_if.rready, 1);
                check("no_fill_mid", fill_done, 0);
                qaddr = ea + 32'(4 * i); #1;
`ifdef LOAD_REFILL_EARLY_HIT_EN
                check("early_hit", qhit, !flushed);
                if (!flushed) check("early_data", qdata, beats[i]);
                qaddr = ea + 32'(4 * (i + 1)); #1;
                check("early_not_arrived", qhit, 0);
`else
                check("no_early_hit", qhit, 0);
`endif
            end
        end
        if (!flushed) begin
            m_valid = 1'b1; m_unc = unc; m_addr = addr;
            for (int i = 0; i < LW; i++) m_line[i] = beats[i];
        end
        check("fill_done", fill_done, !flushed);
        if (!flushed) check("fill_fid", fill_fid, fid);
        check("busy_idle", busy, 0);
        check("rready_off", mem_if.rready, 0);
        qaddr = unc ? addr : ea + 32'(4 * $urandom_range(0, LW - 1)); #1;
        check("post_qhit", qhit, m_hit(qaddr));
        if (m_hit(qaddr)) check("post_qdata", qdata, m_data(qaddr));
        qaddr = addr ^ 32'h0010_0000; #1;
        check("post_miss", qhit, m_hit(qaddr));
        tick();
        check("fill_pulse", fill_done, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic        u;
        logic [1:0]  l;
        mem_if.arready = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0; mem_if.rlast = 1'b0;
        for (int i = 0; i < LW; i++) m_line[i] = '0;

        tick(); tick();
        check_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Cached miss, arready held off while commit keeps re-requesting.
        burst(32'h8000_1234, 1'b0, LSWIDTH_WORD, 5, -1, 32'h0000_00A0);
        qaddr = 32'h8000_123C; #1;
        check("line_hit", qhit, 1);
        check("line_word3", qdata, 32'h0000_00A3);

        a = ar_count;
        rd_en = 1'b1; rd_addr = 32'h8000_1238; rd_unc = 1'b0; rd_lsw = LSWIDTH_WORD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dup_no_ar", mem_if.arvalid, 0);
        end
        rd_en = 1'b0;
        check("dup_ar_count", ar_count - a, 0);

        consume = 1'b1; tick(); consume = 1'b0;
        qaddr = 32'h8000_1230; #1;
        check("cached_consume_keeps", qhit, 1);

        // Uncached byte: served once, consume retires it, re-request goes back to memory.
        burst(32'hBFC0_0003, 1'b1, LSWIDTH_BYTE, 0, -1, 32'h0);
        qaddr = 32'hBFC0_0003; #1;
        check("unc_hit", qhit, 1);
        consume = 1'b1; tick(); consume = 1'b0;
        m_valid = 1'b0;
        check("unc_consumed", qhit, 0);
        burst(32'hBFC0_0003, 1'b1, LSWIDTH_BYTE, 1, -1, 32'h0);
        burst(32'hBFC0_0006, 1'b1, LSWIDTH_HALF, 0, -1, 32'h0);

        // Flush mid-burst drains the beats without filling; the same line is then re-requested.
        burst(32'h8000_2000, 1'b0, LSWIDTH_WORD, 0, 2, 32'h0);
        qaddr = 32'h8000_2000; #1;
        check("flush_no_hit", qhit, 0);
        burst(32'h8000_2000, 1'b0, LSWIDTH_WORD, 0, -1, 32'h0);

        // Flush in IDLE beats a simultaneous request and clears the entry.
        flush = 1'b1; rd_en = 1'b1; rd_addr = 32'h9000_0000; rd_unc = 1'b0;
        tick();
        flush = 1'b0; rd_en = 1'b0; m_valid = 1'b0;
        check("flush_wins_ar", mem_if.arvalid, 0);
        check("flush_wins_busy", busy, 0);
        qaddr = 32'h8000_2004; #1;
        check("flush_idle_clear", qhit, 0);

        for (int k = 0; k < 8; k++) begin
            u = 1'($urandom_range(0, 1));
            l = 2'($urandom_range(0, 2));
            a = $urandom;
            if (m_hit(a)) a = a ^ 32'h0010_0000;
            burst(a, u, l, $urandom_range(0, 3), (!u && $urandom_range(0, 3) == 0) ? $urandom_range(0, LW - 1) : -1, 32'h0);
        end

        // Reset in the middle of a data burst.
        rd_en = 1'b1; rd_addr = 32'h8000_3010; rd_unc = 1'b0; rd_lsw = LSWIDTH_WORD;
        tick();
        rd_en = 1'b0; mem_if.arready = 1'b1;
        tick();
        mem_if.arready = 1'b0;
        check("rst_pre_rdata", mem_if.rready, 1);
        for (int i = 0; i < 2; i++) begin
            mem_if.rvalid = 1'b1; mem_if.rdata = $urandom;
            tick();
        end
        mem_if.rvalid = 1'b0;
        resetn = 1'b0;
        tick();
        m_valid = 1'b0;
        qaddr = 32'h8000_3010; #1;
        check_all_zero("mid_reset");
        resetn = 1'b1;
        tick();
        burst(32'h8000_3010, 1'b0, LSWIDTH_WORD, 0, -1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
